// File: rtl/cpu_control_unit.sv
// Hardwired control-step sequencer: fetch T0-T2, decode IR[31:27], drive execute strobes T3-T7.
// Latency: one control step per clock; outputs decode combinationally from the current step and IR.
// Backpressure: none; stop at the final execute step (or a halt opcode) parks it in HALTED until reset.
module cpu_control_unit #(
    parameter logic [3:0] ALU_ADD = 4'd0,
    parameter logic [3:0] ALU_SUB = 4'd1,
    parameter logic [3:0] ALU_AND = 4'd2,
    parameter logic [3:0] ALU_OR  = 4'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        Branch,
    input  logic        stop,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPc,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zlowout,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        BAout,
    output logic        InPortout,
    output logic        OutPortin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        CONin,
    output logic        read,
    output logic        write,
    output logic [1:0]  mdr_read,
    output logic [3:0]  control,
    output logic        run
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED
    } state_t;

    state_t state_q, state_d;

    logic [4:0] opcode;
    logic       is_alu, is_addi, is_ld, is_st, is_ldst, is_br, is_halt, is_multi;
    logic [3:0] alu_ctl;
    state_t     after_last;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    // Opcode classes; anything not multi-step or halt behaves as a one-step instruction.
    always_comb begin
        is_alu  = 1'b0;
        alu_ctl = ALU_ADD;
        case (opcode)
            OP_ADD: begin is_alu = 1'b1; alu_ctl = ALU_ADD; end
            OP_SUB: begin is_alu = 1'b1; alu_ctl = ALU_SUB; end
            OP_AND: begin is_alu = 1'b1; alu_ctl = ALU_AND; end
            OP_OR:  begin is_alu = 1'b1; alu_ctl = ALU_OR;  end
            default: ;
        endcase
    end

    assign is_addi    = (opcode == OP_ADDI);
    assign is_ld      = (opcode == OP_LD);
    assign is_st      = (opcode == OP_ST);
    assign is_ldst    = is_ld | is_st;
    assign is_br      = (opcode == OP_BR);
    assign is_halt    = (opcode == OP_HALT);
    assign is_multi   = is_alu | is_addi | is_ldst | is_br;
    assign after_last = stop ? S_HALTED : S_T0;

    // Step sequencing: each instruction ends at its own last step and returns to fetch or halts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:    state_d = S_T0;
            S_T0:     state_d = S_T1;
            S_T1:     state_d = S_T2;
            S_T2:     state_d = S_T3;
            S_T3: begin
                if (is_halt)       state_d = S_HALTED;
                else if (is_multi) state_d = S_T4;
                else               state_d = after_last;
            end
            S_T4:     state_d = is_multi ? S_T5 : after_last;
            S_T5:     state_d = (is_ldst | is_br) ? S_T6 : after_last;
            S_T6:     state_d = is_ldst ? S_T7 : after_last;
            S_T7:     state_d = after_last;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RST;
        endcase
    end

    // Step register; reset forces RST at once so every strobe drops without a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_RST;
        else        state_q <= state_d;
    end

    // Strobe decode for the current step; every unlisted strobe stays low.
    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPc = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
        Zlowin = 1'b0; Zlowout = 1'b0; HIout = 1'b0; LOout = 1'b0;
        Cout = 1'b0; BAout = 1'b0; InPortout = 1'b0; OutPortin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        CONin = 1'b0; read = 1'b0; write = 1'b0;
        mdr_read = 2'b00;
        control  = ALU_ADD;
        run      = 1'b0;
        case (state_q)
            S_T0: begin
                run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPc = 1'b1; Zlowin = 1'b1;
            end
            S_T1: begin
                run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; read = 1'b1;
                mdr_read = 2'b01; MDRin = 1'b1;
            end
            S_T2: begin
                run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                run = 1'b1;
                if (is_alu | is_addi) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_ldst) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (is_br) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end else begin
                    case (opcode)
                        OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                        OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                    endcase
                end
            end
            S_T4: begin
                run = 1'b1;
                if (is_alu) begin
                    Grc = 1'b1; Rout = 1'b1; control = alu_ctl; Zlowin = 1'b1;
                end else if (is_addi | is_ldst) begin
                    Cout = 1'b1; Zlowin = 1'b1;
                end else if (is_br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end
            end
            S_T5: begin
                run = 1'b1;
                if (is_alu | is_addi) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_ldst) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (is_br) begin
                    Cout = 1'b1; Zlowin = 1'b1;
                end
            end
            S_T6: begin
                run = 1'b1;
                if (is_ld) begin
                    read = 1'b1; mdr_read = 2'b01; MDRin = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (is_br) begin
                    Zlowout = 1'b1; PCin = Branch;
                end
            end
            S_T7: begin
                run = 1'b1;
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_st) begin
                    write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: instruction-length table, reset/abort sequences, random instruction stream.
// Expected strobes come from a per-instruction step list built from the instruction set description.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_cpu_control_unit;

    logic        clk;
    logic        reset;
    logic [31:0] IR;
    logic        Branch;
    logic        stop;
    logic PCout, PCin, IncPc, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zlowout;
    logic HIout, LOout, Cout, BAout, InPortout, OutPortin;
    logic Gra, Grb, Grc, Rin, Rout, CONin, read, write, run;
    logic [1:0] mdr_read;
    logic [3:0] control;

    cpu_control_unit dut (
        .clk(clk), .reset(reset), .IR(IR), .Branch(Branch), .stop(stop),
        .PCout(PCout), .PCin(PCin), .IncPc(IncPc), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zlowout(Zlowout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .BAout(BAout),
        .InPortout(InPortout), .OutPortin(OutPortin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .CONin(CONin),
        .read(read), .write(write), .mdr_read(mdr_read), .control(control), .run(run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All outputs folded into one word so each step is one comparison.
    logic [30:0] obs;
    assign obs = {control, mdr_read, run, write, read, CONin, Rout, Rin, Grc, Grb, Gra,
                  OutPortin, InPortout, BAout, Cout, LOout, HIout, Zlowout, Zlowin, Yin,
                  IRin, MDRout, MDRin, MARin, IncPc, PCin, PCout};

    localparam logic [30:0] M_PCOUT   = 31'd1 << 0;
    localparam logic [30:0] M_PCIN    = 31'd1 << 1;
    localparam logic [30:0] M_INCPC   = 31'd1 << 2;
    localparam logic [30:0] M_MARIN   = 31'd1 << 3;
    localparam logic [30:0] M_MDRIN   = 31'd1 << 4;
    localparam logic [30:0] M_MDROUT  = 31'd1 << 5;
    localparam logic [30:0] M_IRIN    = 31'd1 << 6;
    localparam logic [30:0] M_YIN     = 31'd1 << 7;
    localparam logic [30:0] M_ZLIN    = 31'd1 << 8;
    localparam logic [30:0] M_ZLOUT   = 31'd1 << 9;
    localparam logic [30:0] M_HIOUT   = 31'd1 << 10;
    localparam logic [30:0] M_LOOUT   = 31'd1 << 11;
    localparam logic [30:0] M_COUT    = 31'd1 << 12;
    localparam logic [30:0] M_BAOUT   = 31'd1 << 13;
    localparam logic [30:0] M_INPORT  = 31'd1 << 14;
    localparam logic [30:0] M_OUTPORT = 31'd1 << 15;
    localparam logic [30:0] M_GRA     = 31'd1 << 16;
    localparam logic [30:0] M_GRB     = 31'd1 << 17;
    localparam logic [30:0] M_GRC     = 31'd1 << 18;
    localparam logic [30:0] M_RIN     = 31'd1 << 19;
    localparam logic [30:0] M_ROUT    = 31'd1 << 20;
    localparam logic [30:0] M_CONIN   = 31'd1 << 21;
    localparam logic [30:0] M_READ    = 31'd1 << 22;
    localparam logic [30:0] M_WRITE   = 31'd1 << 23;
    localparam logic [30:0] M_RUN     = 31'd1 << 24;
    localparam logic [30:0] M_MDRMEM  = 31'd1 << 25;

    localparam logic [30:0] W_T0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLIN;
    localparam logic [30:0] W_T1 = M_RUN | M_ZLOUT | M_PCIN | M_READ | M_MDRMEM | M_MDRIN;
    localparam logic [30:0] W_T2 = M_RUN | M_MDROUT | M_IRIN;

    int total = 0;
    int bad   = 0;
    logic [30:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [30:0] ctl(input logic [3:0] c);
        return {c, 27'd0};
    endfunction

    // Reference: the list of per-step output words for one instruction, fetch included.
    function automatic void build(input logic [4:0] op, input logic br);
        logic [30:0] x;
        exp_q.delete();
        exp_q.push_back(W_T0);
        exp_q.push_back(W_T1);
        exp_q.push_back(W_T2);
        x = M_RUN;
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                logic [3:0] c;
                c = (op == 5'b00011) ? 4'd0 : (op == 5'b00100) ? 4'd1 :
                    (op == 5'b00101) ? 4'd2 : 4'd3;
                exp_q.push_back(x | M_GRB | M_ROUT | M_YIN);
                exp_q.push_back(x | M_GRC | M_ROUT | ctl(c) | M_ZLIN);
                exp_q.push_back(x | M_ZLOUT | M_GRA | M_RIN);
            end
            5'b01100: begin
                exp_q.push_back(x | M_GRB | M_ROUT | M_YIN);
                exp_q.push_back(x | M_COUT | M_ZLIN);
                exp_q.push_back(x | M_ZLOUT | M_GRA | M_RIN);
            end
            5'b00000, 5'b00010: begin
                exp_q.push_back(x | M_GRB | M_BAOUT | M_YIN);
                exp_q.push_back(x | M_COUT | M_ZLIN);
                exp_q.push_back(x | M_ZLOUT | M_MARIN);
                if (op == 5'b00000) begin
                    exp_q.push_back(x | M_READ | M_MDRMEM | M_MDRIN);
                    exp_q.push_back(x | M_MDROUT | M_GRA | M_RIN);
                end else begin
                    exp_q.push_back(x | M_GRA | M_ROUT | M_MDRIN);
                    exp_q.push_back(x | M_WRITE);
                end
            end
            5'b10010: begin
                exp_q.push_back(x | M_GRA | M_ROUT | M_CONIN);
                exp_q.push_back(x | M_PCOUT | M_YIN);
                exp_q.push_back(x | M_COUT | M_ZLIN);
                exp_q.push_back(x | M_ZLOUT | (br ? M_PCIN : 31'd0));
            end
            5'b10011: exp_q.push_back(x | M_GRA | M_ROUT | M_PCIN);
            5'b10110: exp_q.push_back(x | M_INPORT | M_GRA | M_RIN);
            5'b10111: exp_q.push_back(x | M_GRA | M_ROUT | M_OUTPORT);
            5'b11000: exp_q.push_back(x | M_HIOUT | M_GRA | M_RIN);
            5'b11001: exp_q.push_back(x | M_LOOUT | M_GRA | M_RIN);
            default:  exp_q.push_back(x);
        endcase
    endfunction

    // Assert reset, check outputs drop without a clock, release, and land in T0.
    task automatic do_reset();
        reset = 1'b0;
        #2;
        check("reset_async_zero", {1'b0, obs}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_state_zero", {1'b0, obs}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Runs one instruction from T0 against the reference list; stop is random except at the last step.
    task automatic run_model(input logic [4:0] op, input logic br, input logic stp, output logic halted);
        int n;
        build(op, br);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            IR     = (k < 3) ? $urandom : {op, 27'($urandom)};
            Branch = br;
            stop   = (k == n - 1) ? stp : 1'($urandom);
            @(negedge clk);
            check($sformatf("rand_op%0d_step%0d", op, k), {1'b0, obs}, {1'b0, exp_q[k]});
            @(posedge clk); #1;
        end
        halted = (op == 5'b11011) || stp;
    endtask

    task automatic check_halted(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            IR = $urandom; Branch = 1'($urandom); stop = 1'($urandom);
            @(negedge clk);
            check("halted_all_zero", {1'b0, obs}, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [4:0] op;
        logic       br;
        logic       stp;
        int         len;
        logic       halt;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic h;
        reset = 1'b0; IR = '0; Branch = 1'b0; stop = 1'b0;

        tbl[0]  = '{5'b00011, 1'b0, 1'b0, 6, 1'b0};
        tbl[1]  = '{5'b00100, 1'b0, 1'b0, 6, 1'b0};
        tbl[2]  = '{5'b00101, 1'b0, 1'b0, 6, 1'b0};
        tbl[3]  = '{5'b00110, 1'b0, 1'b0, 6, 1'b0};
        tbl[4]  = '{5'b01100, 1'b0, 1'b0, 6, 1'b0};
        tbl[5]  = '{5'b00000, 1'b0, 1'b0, 8, 1'b0};
        tbl[6]  = '{5'b00010, 1'b0, 1'b0, 8, 1'b0};
        tbl[7]  = '{5'b10010, 1'b1, 1'b0, 7, 1'b0};
        tbl[8]  = '{5'b10010, 1'b0, 1'b0, 7, 1'b0};
        tbl[9]  = '{5'b10011, 1'b0, 1'b0, 4, 1'b0};
        tbl[10] = '{5'b10110, 1'b0, 1'b0, 4, 1'b0};
        tbl[11] = '{5'b10111, 1'b0, 1'b0, 4, 1'b0};
        tbl[12] = '{5'b11000, 1'b0, 1'b0, 4, 1'b0};
        tbl[13] = '{5'b11001, 1'b0, 1'b0, 4, 1'b0};
        tbl[14] = '{5'b11010, 1'b0, 1'b0, 4, 1'b0};
        tbl[15] = '{5'b00001, 1'b0, 1'b0, 4, 1'b0};
        tbl[16] = '{5'b11011, 1'b0, 1'b0, 4, 1'b1};
        tbl[17] = '{5'b00011, 1'b0, 1'b1, 6, 1'b1};
        tbl[18] = '{5'b00000, 1'b0, 1'b1, 8, 1'b1};

        do_reset();

        // Table: measure fetch-to-fetch (or fetch-to-halt) length with inputs held constant.
        for (int i = 0; i < 19; i++) begin
            int   cnt;
            logic done, ended_halt;
            do_reset();
            IR = {tbl[i].op, 27'($urandom)};
            Branch = tbl[i].br;
            stop = tbl[i].stp;
            cnt = 0; done = 1'b0; ended_halt = 1'b0;
            while (!done && cnt < 20) begin
                @(posedge clk); #1;
                cnt++;
                @(negedge clk);
                if (!run) begin
                    ended_halt = 1'b1; done = 1'b1;
                end else if (obs == W_T0) begin
                    done = 1'b1;
                end
            end
            check($sformatf("len_op%0d_br%0d_stop%0d", tbl[i].op, tbl[i].br, tbl[i].stp),
                  32'(cnt), 32'(tbl[i].len));
            check($sformatf("halted_op%0d_stop%0d", tbl[i].op, tbl[i].stp),
                  {31'd0, ended_halt}, {31'd0, tbl[i].halt});
        end

        // Reset in the middle of T1 aborts the memory read at once.
        do_reset();
        IR = $urandom; stop = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_fetch_word", {1'b0, obs}, {1'b0, W_T1});
        #2;
        reset = 1'b0;
        #1;
        check("t1_abort_async", {1'b0, obs}, 32'd0);
        @(posedge clk); #1;
        check("held_in_reset", {1'b0, obs}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_after_abort", {1'b0, obs}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t0_after_abort", {1'b0, obs}, {1'b0, W_T0});
        @(posedge clk); #1;

        // Halt after add with stop: stays dark for well over 20 cycles.
        do_reset();
        run_model(5'b00011, 1'b0, 1'b1, h);
        check_halted(25);

        // Random instruction stream against the reference step lists.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [4:0] op;
            logic br, stp;
            op  = 5'($urandom_range(0, 31));
            br  = 1'($urandom);
            stp = ($urandom_range(0, 15) == 0);
            run_model(op, br, stp, h);
            if (h) begin
                check_halted(22);
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
